// File: rtl/debugger_pkg.sv
// Shared definitions for the debugger link: command bytes, RX FSM states and error codes.
package debugger_pkg;

  // Single-byte ASCII commands sent by the host
  localparam logic [7:0] CMD_RUN   = 8'h43; // 'C'
  localparam logic [7:0] CMD_STOP  = 8'h53; // 'S'
  localparam logic [7:0] CMD_RESET = 8'h52; // 'R'
  localparam logic [7:0] CMD_STEP  = 8'h4E; // 'N'
  localparam logic [7:0] CMD_DUMP  = 8'h44; // 'D'
  localparam logic [7:0] CMD_LOAD  = 8'h4C; // 'L'

  // Receive-side FSM encoding, exported on state_reg_rx
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_STEP       = 3'd1,
    ST_WAIT_TX_LO = 3'd2,
    ST_WAIT_TX_HI = 3'd3,
    ST_LEN_HI     = 3'd4,
    ST_LEN_LO     = 3'd5,
    ST_PAYLOAD    = 3'd6
  } rx_state_e;

  // Sticky error reporting
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_UNKNOWN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_LENGTH  = 2'd3;

endpackage

// File: rtl/debugger_rx_ctrl_rx_word_assembler.sv
// Packs received bytes MSB-first into 32-bit words; word_valid is combinational so the
// parent can register the write strobe one cycle after the fourth byte.
module rx_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  assign word_valid = byte_valid && (cnt_q == 2'd3);
  assign word       = {shift_q, byte_in};

  // Next-state for the shift register and byte counter; clr discards a partial word.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clr) begin
      shift_d = 24'd0;
      cnt_d   = 2'd0;
    end else if (byte_valid) begin
      shift_d = {shift_q[15:0], byte_in};
      cnt_d   = cnt_q + 2'd1;
    end else begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= 24'd0;
      cnt_q   <= 2'd0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/debugger_rx_ctrl.sv
// Host-to-board debugger receive controller: decodes command bytes, drives the MIPS
// run/step/reset controls, loads instruction memory and requests dump frames from TX.
module debugger_rx_ctrl
  import debugger_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done_tick,
  input  logic [7:0]        r_data,
  input  logic              dataSent,
  output logic              sendSignal,
  output logic              cpu_run,
  output logic              cpu_step,
  output logic              cpu_rst,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              load_done,
  output logic [1:0]        err_code,
  output logic [2:0]        state_reg_rx
);

  localparam int              TO_W      = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [16:0]     MAX_WORDS = 17'd1 << ADDR_W;

  rx_state_e         state_q, state_d;
  logic              run_q, run_d;
  logic              step_q, step_d;
  logic              rst_q, rst_d;
  logic              send_q, send_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       widx_q, widx_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

  logic        in_load_s;
  logic        expire_s;
  logic [15:0] len_rx_s;
  logic        asm_valid_s;
  logic        asm_clr_s;
  logic        word_valid_s;
  logic [31:0] word_s;

  assign in_load_s   = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                       (state_q == ST_PAYLOAD);
  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign expire_s    = in_load_s && !rx_done_tick && (to_cnt_q == TO_LAST);
  assign len_rx_s    = {len_hi_q, r_data};
  assign asm_valid_s = rx_done_tick && (state_q == ST_PAYLOAD);
  assign asm_clr_s   = (state_q != ST_PAYLOAD);

  rx_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clr        (asm_clr_s),
    .byte_valid (asm_valid_s),
    .byte_in    (r_data),
    .word_valid (word_valid_s),
    .word       (word_s)
  );

  // Inter-byte idle counter, only running while a load command is in progress.
  always_comb begin
    if (rx_done_tick || !in_load_s) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_LAST) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  // Command decode and next-state / registered-output computation.
  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    step_d   = 1'b0;
    rst_d    = 1'b0;
    send_d   = 1'b0;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;
    err_d    = err_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    widx_d   = widx_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_done_tick) begin
          case (r_data)
            CMD_RUN: begin
              run_d = 1'b1;
              err_d = ERR_NONE;
            end
            CMD_STOP: begin
              run_d = 1'b0;
              err_d = ERR_NONE;
            end
            CMD_RESET: begin
              run_d = 1'b0;
              rst_d = 1'b1;
              err_d = ERR_NONE;
            end
            CMD_STEP: begin
              // Stepping a free-running core is meaningless; only the dump happens.
              step_d  = !run_q;
              err_d   = ERR_NONE;
              state_d = ST_STEP;
            end
            CMD_DUMP: begin
              send_d  = 1'b1;
              err_d   = ERR_NONE;
              state_d = ST_WAIT_TX_LO;
            end
            CMD_LOAD: begin
              run_d   = 1'b0;
              err_d   = ERR_NONE;
              state_d = ST_LEN_HI;
            end
            default: begin
              err_d = ERR_UNKNOWN;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_STEP: begin
        send_d  = 1'b1;
        state_d = ST_WAIT_TX_LO;
      end

      ST_WAIT_TX_LO: begin
        if (!dataSent) begin
          state_d = ST_WAIT_TX_HI;
        end else begin
          state_d = ST_WAIT_TX_LO;
        end
      end

      ST_WAIT_TX_HI: begin
        if (dataSent) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_TX_HI;
        end
      end

      ST_LEN_HI: begin
        if (rx_done_tick) begin
          len_hi_d = r_data;
          state_d  = ST_LEN_LO;
        end else if (expire_s) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LEN_HI;
        end
      end

      ST_LEN_LO: begin
        if (rx_done_tick) begin
          if (len_rx_s == 16'd0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if ({1'b0, len_rx_s} > MAX_WORDS) begin
            err_d   = ERR_LENGTH;
            state_d = ST_IDLE;
          end else begin
            len_d   = len_rx_s;
            widx_d  = 16'd0;
            state_d = ST_PAYLOAD;
          end
        end else if (expire_s) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LEN_LO;
        end
      end

      ST_PAYLOAD: begin
        if (word_valid_s) begin
          we_d    = 1'b1;
          addr_d  = widx_q[ADDR_W-1:0];
          wdata_d = word_s;
          if (widx_q == (len_q - 16'd1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            widx_d = widx_q + 16'd1;
          end
        end else if (expire_s) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PAYLOAD;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All state and outputs registered; reset discards any partial load.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      run_q    <= 1'b0;
      step_q   <= 1'b0;
      rst_q    <= 1'b0;
      send_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      done_q   <= 1'b0;
      err_q    <= ERR_NONE;
      len_hi_q <= 8'd0;
      len_q    <= 16'd0;
      widx_q   <= 16'd0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      step_q   <= step_d;
      rst_q    <= rst_d;
      send_q   <= send_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      widx_q   <= widx_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  assign sendSignal   = send_q;
  assign cpu_run      = run_q;
  assign cpu_step     = step_q;
  assign cpu_rst      = rst_q;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign load_done    = done_q;
  assign err_code     = err_q;
  assign state_reg_rx = state_q;

endmodule
